// File: rtl/mux.sv
// Registered 3-to-1 shape-code selector.
// Select 3 is reserved and loads all-zeros.
module mux #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cuadrado,
   input  logic [WIDTH-1:0] circulo,
   input  logic [WIDTH-1:0] recta,
   input  logic [1:0]       selec,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;

   // Unknown select bits fall into the default branch
   always_comb begin
      out_d = '0;
      unique case (1'b1)
         (selec == 2'b00): out_d = cuadrado;
         (selec == 2'b01): out_d = circulo;
         (selec == 2'b10): out_d = recta;
         default:          out_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux at WIDTH=2 and WIDTH=4.
// Random and directed steps against a table-lookup model.
module tb_mux;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] selec;
   logic [3:0] cua, cir, rec;
   logic [1:0] out2;
   logic [3:0] out4;
   logic [3:0] exp_v;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   mux #(.WIDTH(2)) u_w2 (
      .clk      (clk),
      .rst      (rst),
      .cuadrado (cua[1:0]),
      .circulo  (cir[1:0]),
      .recta    (rec[1:0]),
      .selec    (selec),
      .out      (out2)
   );

   mux #(.WIDTH(4)) u_w4 (
      .clk      (clk),
      .rst      (rst),
      .cuadrado (cua),
      .circulo  (cir),
      .recta    (rec),
      .selec    (selec),
      .out      (out4)
   );

   // Reference: reset wins, else index a table of sources
   function automatic logic [3:0] pick(
      input logic       r,
      input logic [1:0] s,
      input logic [3:0] a,
      input logic [3:0] b,
      input logic [3:0] c
   );
      logic [3:0] tbl [4];
      tbl[0] = a;
      tbl[1] = b;
      tbl[2] = c;
      tbl[3] = 4'h0;
      if (r) return 4'h0;
      return tbl[s];
   endfunction

   task automatic chk(
      input string      tag,
      input logic [3:0] obs,
      input logic [3:0] expv
   );
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
      end
   endtask

   task automatic step(
      input string      tag,
      input logic       r,
      input logic [1:0] s,
      input logic [3:0] a,
      input logic [3:0] b,
      input logic [3:0] c
   );
      @(negedge clk);
      rst   = r;
      selec = s;
      cua   = a;
      cir   = b;
      rec   = c;
      exp_v = pick(r, s, a, b, c);
      @(posedge clk);
      #1;
      chk({tag, "_w2"}, {2'b00, out2}, exp_v & 4'h3);
      chk({tag, "_w4"}, out4, exp_v);
   endtask

   initial begin
      rst   = 1'b1;
      selec = 2'b00;
      cua   = 4'h3;
      cir   = 4'h1;
      rec   = 4'h2;

      step("rst1", 1'b1, 2'b00, 4'h3, 4'h1, 4'h2);
      step("rst2", 1'b1, 2'b00, 4'h3, 4'h1, 4'h2);
      step("rel",  1'b0, 2'b00, 4'h3, 4'h1, 4'h2);

      step("sq", 1'b0, 2'b00, 4'h3, 4'h1, 4'h2);
      #2;
      cua = 4'h1;
      #1;
      chk("hold_w2", {2'b00, out2}, 4'h3);
      chk("hold_w4", out4, 4'h3);
      step("sq2", 1'b0, 2'b00, 4'h1, 4'h1, 4'h2);

      step("ci",  1'b0, 2'b01, 4'h0, 4'h1, 4'h2);
      step("li",  1'b0, 2'b10, 4'h3, 4'h1, 4'h2);
      step("res", 1'b0, 2'b11, 4'h3, 4'h1, 4'h2);

      step("mid0", 1'b0, 2'b10, 4'h3, 4'h1, 4'h2);
      step("mid1", 1'b1, 2'b10, 4'h3, 4'h1, 4'h2);
      step("mid2", 1'b0, 2'b10, 4'h3, 4'h1, 4'h2);

      step("w4sq", 1'b0, 2'b00, 4'hA, 4'h5, 4'hF);
      step("w4ci", 1'b0, 2'b01, 4'hA, 4'h5, 4'hF);
      step("w4li", 1'b0, 2'b10, 4'hA, 4'h5, 4'hF);
      step("w4rs", 1'b0, 2'b11, 4'hA, 4'h5, 4'hF);

      for (int i = 0; i < 200; i++) begin
         step("rnd",
              ($urandom_range(15) == 0),
              2'($urandom_range(3)),
              4'($urandom),
              4'($urandom),
              4'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
